// File: rtl/fetch_pc_gen_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pc_gen_pkg
//   Shared widths, the default reset PC and small PC helper functions for the
//   instruction-fetch front end (fetch_pc_gen) and its optional BTB
//   (fetch_btb).
// ---------------------------------------------------------------------------
package fetch_pc_gen_pkg;

    localparam int          ID_TO_IF_BUS_WD  = 33;
    localparam int          IF_TO_IPD_BUS_WD = 96;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h1C00_0000;

    // Sequential successor; 32'hFFFF_FFFC wraps to 0.
    function automatic logic [31:0] seq_next_pc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

    // Fetch addresses are always word aligned.
    function automatic logic [31:0] word_align(input logic [31:0] pc);
        return {pc[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_btb.sv
// ---------------------------------------------------------------------------
// fetch_btb
//   Direct-mapped branch target buffer used by fetch_pc_gen when the
//   SIMPLECPU_BTB_EN macro is defined. Without the macro this file
//   contributes no module at all, so no BTB storage can be synthesised.
//
//   Entry: {valid, tag = pc[31:2+IDX_W], target}, index = pc[2 +: IDX_W].
//
// Ports
//   clk           in   clock
//   reset         in   synchronous active-high; clears all valid bits
//   i_lookup_pc   in   32  address to predict (combinational lookup)
//   o_hit         out  1   entry valid and tag matches
//   o_target      out  32  stored target of the indexed entry
//   i_upd_en      in   1   write an entry at posedge
//   i_upd_pc      in   32  branch PC being recorded
//   i_upd_target  in   32  its taken target
// ---------------------------------------------------------------------------
`ifdef SIMPLECPU_BTB_EN
module fetch_btb
    import fetch_pc_gen_pkg::*;
#(
    parameter int ENTRIES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] i_lookup_pc,
    output logic        o_hit,
    output logic [31:0] o_target,
    input  logic        i_upd_en,
    input  logic [31:0] i_upd_pc,
    input  logic [31:0] i_upd_target
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = 30 - IDX_W;

    logic [ENTRIES-1:0] r_valid;
    logic [TAG_W-1:0]   r_tag    [ENTRIES];
    logic [31:0]        r_target [ENTRIES];

    logic [IDX_W-1:0]   w_lookup_idx;
    logic [IDX_W-1:0]   w_upd_idx;

    assign w_lookup_idx = i_lookup_pc[2 +: IDX_W];
    assign w_upd_idx    = i_upd_pc[2 +: IDX_W];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= '0;
        end else if (i_upd_en) begin
            r_valid[w_upd_idx] <= 1'b1;
        end
    end

    // NOTE: tag/target arrays are left unreset; the valid bits alone decide
    // whether an entry is meaningful, so resetting the RAM would only cost logic.
    always_ff @(posedge clk) begin
        if (i_upd_en && !reset) begin
            r_tag[w_upd_idx]    <= i_upd_pc[31 -: TAG_W];
            r_target[w_upd_idx] <= i_upd_target;
        end
    end

    // Reads see the array before this cycle's write lands at the edge.
    assign o_hit    = r_valid[w_lookup_idx] &&
                      (r_tag[w_lookup_idx] == i_lookup_pc[31 -: TAG_W]);
    assign o_target = r_target[w_lookup_idx];

endmodule
`endif

// File: rtl/fetch_pc_gen.sv
// ---------------------------------------------------------------------------
// fetch_pc_gen
//   Instruction-fetch front end. Generates fetch PCs, drives a synchronous
//   instruction SRAM (data one cycle after the request), holds the returned
//   instruction under IPD back-pressure and attaches a predicted next PC.
//   A redirect from ID (br_taken_cancel) flushes all wrong-path state and
//   refetches from PC_fromID in the same cycle.
//
//   Optional feature macro: SIMPLECPU_BTB_EN (adds fetch_btb and btb_* ports;
//   otherwise the prediction is always addr+4).
//
// Ports
//   clk              in   clock, all state on posedge
//   reset            in   synchronous active-high
//   ID_to_IF_bus     in   33  {br_taken_cancel, PC_fromID}
//   IPD_allow_in     in   1   IPD accepts this cycle
//   btb_upd_en       in   1   [BTB] ID resolved a taken branch
//   btb_upd_pc       in   32  [BTB] its PC
//   btb_upd_target   in   32  [BTB] its target
//   IF_to_IPD_valid  out  1   IF_to_IPD_bus holds a valid instruction
//   IF_to_IPD_bus    out  96  {pred_PC, inst_PC, inst}
//   inst_sram_en     out  1   read request
//   inst_sram_addr   out  32  word-aligned fetch address
//   inst_sram_rdata  in   32  read data, valid the cycle after the request
// ---------------------------------------------------------------------------
module fetch_pc_gen
    import fetch_pc_gen_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
`ifdef SIMPLECPU_BTB_EN
    ,
    parameter int          BTB_ENTRIES = 16
`endif
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [ID_TO_IF_BUS_WD-1:0]  ID_to_IF_bus,
    input  logic                        IPD_allow_in,
`ifdef SIMPLECPU_BTB_EN
    input  logic                        btb_upd_en,
    input  logic [31:0]                 btb_upd_pc,
    input  logic [31:0]                 btb_upd_target,
`endif
    output logic                        IF_to_IPD_valid,
    output logic [IF_TO_IPD_BUS_WD-1:0] IF_to_IPD_bus,
    output logic                        inst_sram_en,
    output logic [31:0]                 inst_sram_addr,
    input  logic [31:0]                 inst_sram_rdata
);

    logic        w_br_taken_cancel;
    logic [31:0] w_pc_from_id;

    logic [31:0] r_fetch_pc;
    logic        r_if_valid;
    logic [31:0] r_if_pc;
    logic [31:0] r_if_pred_pc;
    logic [31:0] r_inst_buf;
    logic        r_buf_valid;

    logic        w_if_allow_in;
    logic        w_req_fire;
    logic        w_stall_capture;
    logic [31:0] w_addr;
    logic [31:0] w_pred_pc;
    logic [31:0] w_inst;

    assign {w_br_taken_cancel, w_pc_from_id} = ID_to_IF_bus;

    assign w_if_allow_in = ~r_if_valid | IPD_allow_in;
    // A redirect always issues, even while IPD is stalling.
    assign w_req_fire    = ~reset & (w_br_taken_cancel | w_if_allow_in);
    assign w_addr        = w_br_taken_cancel ? word_align(w_pc_from_id) : r_fetch_pc;

    // The SRAM only holds its output for one cycle, so the first stalled
    // cycle must copy it before it is overwritten.
    assign w_stall_capture = r_if_valid & ~IPD_allow_in & ~r_buf_valid;

`ifdef SIMPLECPU_BTB_EN
    logic        w_btb_hit;
    logic [31:0] w_btb_target;

    fetch_btb #(
        .ENTRIES      (BTB_ENTRIES)
    ) u_fetch_btb (
        .clk          (clk),
        .reset        (reset),
        .i_lookup_pc  (w_addr),
        .o_hit        (w_btb_hit),
        .o_target     (w_btb_target),
        .i_upd_en     (btb_upd_en),
        .i_upd_pc     (btb_upd_pc),
        .i_upd_target (btb_upd_target)
    );

    assign w_pred_pc = w_btb_hit ? w_btb_target : seq_next_pc(w_addr);
`else
    assign w_pred_pc = seq_next_pc(w_addr);
`endif

    // Control state: a request (new or redirect) wins over capturing the
    // stalled instruction, which is what discards the buffer on a redirect.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetch_pc  <= RESET_PC;
            r_if_valid  <= 1'b0;
            r_buf_valid <= 1'b0;
        end else if (w_req_fire) begin
            r_fetch_pc  <= w_pred_pc;
            r_if_valid  <= 1'b1;
            r_buf_valid <= 1'b0;
        end else if (w_stall_capture) begin
            r_buf_valid <= 1'b1;
        end
    end

    // Payload registers are only observed while r_if_valid/r_buf_valid say
    // so, hence no reset. w_req_fire already excludes reset.
    always_ff @(posedge clk) begin
        if (w_req_fire) begin
            r_if_pc      <= w_addr;
            r_if_pred_pc <= w_pred_pc;
        end
        if (w_stall_capture) begin
            r_inst_buf <= inst_sram_rdata;
        end
    end

    assign w_inst          = r_buf_valid ? r_inst_buf : inst_sram_rdata;
    assign IF_to_IPD_valid = r_if_valid;
    assign IF_to_IPD_bus   = {r_if_pred_pc, r_if_pc, w_inst};
    assign inst_sram_en    = w_req_fire;
    assign inst_sram_addr  = w_addr;

endmodule

// File: tb/tb_fetch_pc_gen.sv
// ---------------------------------------------------------------------------
// tb_fetch_pc_gen
//   Directed bench for fetch_pc_gen. A transaction-level model tracks which
//   PC the IF stage should be presenting; since the SRAM content is a pure
//   function of the address, the presented instruction must always equal
//   mem(inst_PC) no matter how the DUT buffers it. A negedge compare process
//   checks every cycle; the directed sequence adds literal expectations.
// ---------------------------------------------------------------------------
module tb_fetch_pc_gen;

    localparam logic [31:0] RST_PC = 32'h1C00_0000;

    logic        clk;
    logic        reset;
    logic        cancel;
    logic [31:0] pc_from_id;
    logic        allow;
    logic [32:0] id_bus;
    logic        if_valid;
    logic [95:0] if_bus;
    logic        sram_en;
    logic [31:0] sram_addr;
    logic [31:0] sram_rdata;
`ifdef SIMPLECPU_BTB_EN
    logic        upd_en;
    logic [31:0] upd_pc;
    logic [31:0] upd_tgt;
`endif

    int n_vec = 0;
    int n_bad = 0;

    assign id_bus = {cancel, pc_from_id};

    fetch_pc_gen dut (
        .clk             (clk),
        .reset           (reset),
        .ID_to_IF_bus    (id_bus),
        .IPD_allow_in    (allow),
`ifdef SIMPLECPU_BTB_EN
        .btb_upd_en      (upd_en),
        .btb_upd_pc      (upd_pc),
        .btb_upd_target  (upd_tgt),
`endif
        .IF_to_IPD_valid (if_valid),
        .IF_to_IPD_bus   (if_bus),
        .inst_sram_en    (sram_en),
        .inst_sram_addr  (sram_addr),
        .inst_sram_rdata (sram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory contents: distinct for every word address.
    function automatic logic [31:0] mem(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hA5C3_0F1E;
    endfunction

    // Synchronous SRAM: data one cycle after a request, garbage otherwise.
    always @(posedge clk) begin
        sram_rdata <= sram_en ? mem(sram_addr) : 32'hDEAD_BEEF;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    logic        m_valid = 1'b0;
    logic [31:0] m_pc    = '0;
    logic [31:0] m_pred  = '0;
    logic [31:0] m_next  = RST_PC;
`ifdef SIMPLECPU_BTB_EN
    logic        m_bv   [16];
    logic [31:0] m_bpc  [16];
    logic [31:0] m_btgt [16];
`endif

    function automatic logic [31:0] model_pred(input logic [31:0] a);
`ifdef SIMPLECPU_BTB_EN
        logic [3:0] idx;
        idx = a[5:2];
        if (m_bv[idx] && (m_bpc[idx][31:2] == a[31:2])) return m_btgt[idx];
`endif
        return a + 32'd4;
    endfunction

    function automatic logic [31:0] model_addr();
        return cancel ? {pc_from_id[31:2], 2'b00} : m_next;
    endfunction

    function automatic logic model_fire();
        return !reset && (cancel || !m_valid || allow);
    endfunction

    always @(posedge clk) begin
        logic [31:0] a;
        if (reset) begin
            m_valid = 1'b0;
            m_next  = RST_PC;
`ifdef SIMPLECPU_BTB_EN
            for (int i = 0; i < 16; i++) m_bv[i] = 1'b0;
`endif
        end else begin
            if (model_fire()) begin
                a       = model_addr();
                m_pc    = a;
                m_pred  = model_pred(a);
                m_next  = m_pred;
                m_valid = 1'b1;
            end
`ifdef SIMPLECPU_BTB_EN
            if (upd_en) begin
                m_bv[upd_pc[5:2]]   = 1'b1;
                m_bpc[upd_pc[5:2]]  = upd_pc;
                m_btgt[upd_pc[5:2]] = upd_tgt;
            end
`endif
        end
    end

    // Compare process: every cycle after the first clock edge.
    always @(negedge clk) begin
        check("valid", {31'd0, if_valid}, {31'd0, m_valid});
        check("sram_en", {31'd0, sram_en}, {31'd0, model_fire()});
        if (model_fire()) check("sram_addr", sram_addr, model_addr());
        if (m_valid) begin
            check("inst_PC", if_bus[63:32], m_pc);
            check("pred_PC", if_bus[95:64], m_pred);
            check("inst", if_bus[31:0], mem(m_pc));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic drive(input logic r, input logic c, input logic [31:0] pc, input logic a);
        @(posedge clk);
        #1;
        reset      = r;
        cancel     = c;
        pc_from_id = pc;
        allow      = a;
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; cancel = 1'b0; pc_from_id = '0; allow = 1'b1;
`ifdef SIMPLECPU_BTB_EN
        upd_en = 1'b0; upd_pc = '0; upd_tgt = '0;
`endif
        drive(1, 0, 0, 1);
        check("rst_valid", {31'd0, if_valid}, 32'd0);
        check("rst_en", {31'd0, sram_en}, 32'd0);
        drive(1, 0, 0, 1);

        // Reset release, streaming.
        drive(0, 0, 0, 1);
        check("first_addr", sram_addr, 32'h1C00_0000);
        check("first_valid", {31'd0, if_valid}, 32'd0);
        drive(0, 0, 0, 1);
        check("addr1", sram_addr, 32'h1C00_0004);
        check("pc0", if_bus[63:32], 32'h1C00_0000);
        check("pred0", if_bus[95:64], 32'h1C00_0004);

        // Stall three cycles holding 1C000004.
        drive(0, 0, 0, 0);
        check("stall_en", {31'd0, sram_en}, 32'd0);
        check("stall_pc", if_bus[63:32], 32'h1C00_0004);
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);
        check("stall_rdata_junk", sram_rdata, 32'hDEAD_BEEF);
        check("stall_inst", if_bus[31:0], mem(32'h1C00_0004));
        drive(0, 0, 0, 1);
        check("release_addr", sram_addr, 32'h1C00_0008);
        drive(0, 0, 0, 1);
        check("pc8", if_bus[63:32], 32'h1C00_0008);

        // Redirect while stalled with a buffered instruction.
        drive(0, 0, 0, 0);
        drive(0, 1, 32'h1C00_0103, 0);
        check("redir_en", {31'd0, sram_en}, 32'd1);
        check("redir_addr", sram_addr, 32'h1C00_0100);
        drive(0, 0, 0, 0);
        check("redir_pc", if_bus[63:32], 32'h1C00_0100);
        check("redir_valid", {31'd0, if_valid}, 32'd1);
        check("redir_inst", if_bus[31:0], mem(32'h1C00_0100));
        drive(0, 0, 0, 1);
        check("after_redir_addr", sram_addr, 32'h1C00_0104);

        // Redirect with IPD accepting, to the top of the address space.
        drive(0, 1, 32'hFFFF_FFFC, 1);
        check("top_addr", sram_addr, 32'hFFFF_FFFC);
        drive(0, 0, 0, 1);
        check("wrap_pred", if_bus[95:64], 32'h0000_0000);
        check("wrap_addr", sram_addr, 32'h0000_0000);
        drive(0, 0, 0, 1);
        check("zero_pc", if_bus[63:32], 32'h0000_0000);

        // Reset during a buffered stall (and during a redirect).
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);
        drive(1, 1, 32'h1C00_0300, 0);
        check("rst_redir_en", {31'd0, sram_en}, 32'd0);
        drive(1, 0, 0, 0);
        check("rst_stall_valid", {31'd0, if_valid}, 32'd0);
        check("rst_stall_en", {31'd0, sram_en}, 32'd0);
        drive(0, 0, 0, 1);
        check("rerun_addr", sram_addr, 32'h1C00_0000);
`ifdef SIMPLECPU_BTB_EN
        upd_en = 1'b1; upd_pc = 32'h1C00_0010; upd_tgt = 32'h1C00_0200;
`endif
        drive(0, 0, 0, 1);
`ifdef SIMPLECPU_BTB_EN
        upd_en = 1'b0;
`endif
        drive(0, 0, 0, 1);
        drive(0, 0, 0, 1);
        drive(0, 0, 0, 1);
        check("addr10", sram_addr, 32'h1C00_0010);
        drive(0, 0, 0, 1);
        check("pc10", if_bus[63:32], 32'h1C00_0010);
`ifdef SIMPLECPU_BTB_EN
        check("btb_pred", if_bus[95:64], 32'h1C00_0200);
        check("btb_next_addr", sram_addr, 32'h1C00_0200);
`else
        check("seq_pred", if_bus[95:64], 32'h1C00_0014);
        check("seq_next_addr", sram_addr, 32'h1C00_0014);
`endif
        // Same index as 1C000010, different tag: must not hit.
        drive(0, 1, 32'h1C00_0050, 1);
        drive(0, 0, 0, 1);
        check("alias_pc", if_bus[63:32], 32'h1C00_0050);
        check("alias_pred", if_bus[95:64], 32'h1C00_0054);
        check("alias_addr", sram_addr, 32'h1C00_0054);
        drive(0, 0, 0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
